// File: rtl/comparator_serial_acc.sv
// rtl/comparator_serial_acc.sv - serial MSB-first magnitude comparator with per-result word counters
module comparator_serial_acc #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 7,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             start,
    input  logic             last,
    input  logic             a,
    input  logic             b,
    input  logic             clr_cnt,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic [LEN_W-1:0] len,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN_EQ = 2'd1;
    localparam logic [1:0] S_RUN_GT = 2'd2;
    localparam logic [1:0] S_RUN_LT = 2'd3;

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    logic             done_q, done_d, err_q, err_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d, eq_cnt_q, eq_cnt_d, lt_cnt_q, lt_cnt_d;
    logic             finish;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gt_d      = gt_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        len_d     = len_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        finish    = 1'b0;
        gt_cnt_d  = gt_cnt_q;
        eq_cnt_d  = eq_cnt_q;
        lt_cnt_d  = lt_cnt_q;

        if (bit_valid) begin
            if (start) begin
                // A start always wins: any word in progress is silently abandoned.
                bit_cnt_d = LEN_W'(1);
                if (a && !b)      state_d = S_RUN_GT;
                else if (!a && b) state_d = S_RUN_LT;
                else              state_d = S_RUN_EQ;
                finish = last;
            end else if (state_q != S_IDLE) begin
                if (bit_cnt_q >= MAX_LEN_C) begin
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + LEN_W'(1);
                    if (state_q == S_RUN_EQ) begin
                        if (a && !b)      state_d = S_RUN_GT;
                        else if (!a && b) state_d = S_RUN_LT;
                    end
                    finish = last;
                end
            end
        end

        if (finish) begin
            gt_d    = (state_d == S_RUN_GT);
            eq_d    = (state_d == S_RUN_EQ);
            lt_d    = (state_d == S_RUN_LT);
            len_d   = bit_cnt_d;
            done_d  = 1'b1;
            state_d = S_IDLE;
        end

        if (clr_cnt) begin
            gt_cnt_d = '0;
            eq_cnt_d = '0;
            lt_cnt_d = '0;
        end else if (finish) begin
            if (gt_d && gt_cnt_q != CNT_MAX) gt_cnt_d = gt_cnt_q + CNT_W'(1);
            if (eq_d && eq_cnt_q != CNT_MAX) eq_cnt_d = eq_cnt_q + CNT_W'(1);
            if (lt_d && lt_cnt_q != CNT_MAX) lt_cnt_d = lt_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            len_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            gt_cnt_q  <= '0;
            eq_cnt_q  <= '0;
            lt_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gt_q      <= gt_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            len_q     <= len_d;
            done_q    <= done_d;
            err_q     <= err_d;
            gt_cnt_q  <= gt_cnt_d;
            eq_cnt_q  <= eq_cnt_d;
            lt_cnt_q  <= lt_cnt_d;
        end
    end

    assign gt     = gt_q;
    assign eq     = eq_q;
    assign lt     = lt_q;
    assign len    = len_q;
    assign done   = done_q;
    assign err    = err_q;
    assign busy   = (state_q != S_IDLE);
    assign gt_cnt = gt_cnt_q;
    assign eq_cnt = eq_cnt_q;
    assign lt_cnt = lt_cnt_q;

endmodule

// File: doc/comparator_serial_acc.md
COMPARATOR_SERIAL_ACC -- requirements
Module: comparator_serial_acc

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 16, meaning the maximum number of bit pairs per word (2..64).
REQ-002 The block SHALL have parameter LEN_W, default 7, meaning the width of the length counter and len output; it SHALL hold MAX_LEN+1.
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning the width of each result counter.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 bit_valid  input  1  a/b/start/last are sampled only when high.
REQ-007 start  input  1  qualified by bit_valid; marks the first (MSB) bit pair of a word.
REQ-008 last  input  1  qualified by bit_valid; marks the final (LSB) bit pair of a word.
REQ-009 a  input  1  serial operand A bit, MSB first.
REQ-010 b  input  1  serial operand B bit, MSB first.
REQ-011 clr_cnt  input  1  synchronous clear of gt_cnt/eq_cnt/lt_cnt.
REQ-012 gt  output  1  registered result, last completed word A>B.
REQ-013 eq  output  1  registered result, last completed word A==B.
REQ-014 lt  output  1  registered result, last completed word A<B.
REQ-015 done  output  1  one-cycle pulse, new result on gt/eq/lt.
REQ-016 busy  output  1  high while a word is in progress.
REQ-017 err  output  1  one-cycle pulse, word exceeded MAX_LEN bits.
REQ-018 len  output  LEN_W  bit count of the last completed word.
REQ-019 gt_cnt, eq_cnt, lt_cnt  output  CNT_W each  saturating counts of completed words by result.

Function
REQ-020 FSM states SHALL be IDLE, RUN_EQ, RUN_GT and RUN_LT; busy = (state != IDLE).
REQ-021 A beat is a cycle with bit_valid=1; non-beat cycles SHALL change no state.
REQ-022 In IDLE, a beat with start=0 SHALL be ignored.
REQ-023 A beat with start=1, in any state, SHALL begin a new word: bit count set to 1; next state RUN_GT if a>b, RUN_LT if a<b, else RUN_EQ.
REQ-024 A start beat while busy SHALL abort the word in progress: no done, no count update, gt/eq/lt/len unchanged.
REQ-025 A non-start beat in RUN_EQ SHALL go to RUN_GT if a=1,b=0, to RUN_LT if a=0,b=1, else stay in RUN_EQ; bit count increments.
REQ-026 A non-start beat in RUN_GT or RUN_LT SHALL keep the state (MSB decides); bit count increments.
REQ-027 A beat with last=1 SHALL complete the word, including the start+last single-bit case.
REQ-028 On completion, on the next clock edge: gt/eq/lt SHALL reflect the final state (exactly one high); len = bit count; done=1 for one cycle; state = IDLE.
REQ-029 The done-to-next-start latency SHALL be zero: a start beat in the cycle done is high SHALL be accepted.
REQ-030 If a non-start beat would make the bit count exceed MAX_LEN, err SHALL pulse for one cycle, the word SHALL be dropped (no done, no count update) and state SHALL return to IDLE, whether or not last is set.
REQ-031 On done, the counter matching the result SHALL increment by 1 and saturate at 2^CNT_W-1.
REQ-032 clr_cnt SHALL zero all three counters and SHALL take priority over a same-cycle increment; that increment is lost.
REQ-033 gt/eq/lt/len SHALL hold their values between completions.

Reset
REQ-034 While rst_n=0: state=IDLE, gt=eq=lt=0, done=0, err=0, busy=0, len=0, all counters=0, bit count=0.
REQ-035 Reset asserted mid-word SHALL discard the word with no done; the first start beat after deassertion SHALL be accepted normally.

Verification
REQ-036 Word A=1011, B=1001 (MSB first, 4 beats) -> one cycle after the last beat: gt=1, eq=0, lt=0, len=4, done pulse, gt_cnt=1.
REQ-037 Single beat with start=1, last=1, a=b=1 -> eq=1, len=1, eq_cnt increments; then a back-to-back start in the done cycle is accepted.
REQ-038 Start, 2 beats, then a new start (abort), then A=01, B=10 -> a single done only, lt=1, len=2, lt_cnt=1.
REQ-039 17 non-last beats with MAX_LEN=16 -> err pulse on the 17th, busy=0, no done, counters unchanged.
REQ-040 255 gt words with CNT_W=8, then one more -> gt_cnt=255 held; clr_cnt asserted in a done cycle -> all counters 0.
REQ-041 rst_n pulsed low mid-word -> all outputs 0 asynchronously; no done follows; next word completes correctly.
